red_pitaya_iq_sincos_gen: RTL and testbench
===========================================

Name: red_pitaya_iq_sincos_gen

Overview:
Numerically controlled oscillator producing the signed sin/cos pair consumed by the IQ modulator's sin and cos inputs. It contains a phase accumulator with a programmable frequency word and phase offset. The output is generated from a quarter-wave lookup table with quadrant mirroring. The pipeline is fixed-latency and the sin and cos outputs are phase-coherent, so the downstream second products need no extra alignment.

Parameters:
PHASEBITS, 32, phase accumulator / frequency word / phase offset width
LUTBITS, 11, phase bits used for table addressing (full circle = 2^LUTBITS points)
SINBITS, 14, output width; must match the modulator's SINBITS

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
freq_i  input  PHASEBITS  unsigned phase increment per clock
phase_i  input  PHASEBITS  unsigned phase offset, added after the accumulator
sync_i  input  1  clears the phase accumulator (phase alignment between generators)
sin_o  output  SINBITS  signed sine, registered
cos_o  output  SINBITS  signed cosine, registered
phase_o  output  PHASEBITS  accumulator value aligned with sin_o/cos_o, registered
valid_o  output  1  high once the pipeline holds post-reset data

Behaviour:
- Reset (rst_i=1 at a clock edge): accumulator=0; all pipeline registers=0; sin_o=0, cos_o=0, phase_o=0, valid_o=0. Reset asserted mid-operation behaves identically and takes effect on the same edge.
- Accumulator: acc <= acc + freq_i, wrapping modulo 2^PHASEBITS. sync_i=1: acc <= 0, which overrides the increment. freq_i changes affect the next increment only, with no phase jump.
- Stage 1 (registered): p <= acc + phase_i modulo 2^PHASEBITS. The cosine phase is pc = p + 2^(PHASEBITS-2).
- Address split for each of p and pc: quadrant q = top 2 bits; index i = next LUTBITS-2 bits; lower bits are truncated (no rounding).
- Table: N = 2^(LUTBITS-2) entries, T[k] = round((2^(SINBITS-1)-1) * sin(2*pi*(k+0.5)/2^LUTBITS)), all positive.
  - The half-LSB offset makes mirroring exact, so no zero entry and no N-th entry exist.
  - Initialised at elaboration from a generate/function; no runtime writes.
  - One table shared by sin and cos via two read ports.
- Stage 2 (registered): mirrored address, i for q=0 or 2, N-1-i for q=1 or 3. Table read and the sign bit (q[1]) are registered.
- Stage 3 (registered): output = sign ? -T : +T. Result always lies in ±(2^(SINBITS-1)-1); the most negative code never occurs.
- Latency: the acc value present at edge n appears on sin_o/cos_o/phase_o at edge n+3. phase_o is acc delayed 3 cycles and excludes phase_i.
- valid_o: a 2-bit fill counter from reset; goes high on the 3rd edge after reset release and stays high. sync_i does not drop valid_o.
- Simultaneous sync_i and rst_i: reset wins (identical result).
- freq_i=0: constant output. freq_i=2^(PHASEBITS-1): alternating ±T[0] on sin_o.

Optional Feature:
Macro IQ_SINCOS_DITHER_EN.
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, steps every cycle) supplies uniform noise.
  - The noise is added to the bits of p below the LUT address, aligned so the LFSR MSB weighs half an address LSB (zero-padded if fewer than 16 such bits).
  - The addition is inside stage 1 and does not change latency.
  - The same dithered p is used for both sin and cos.
- Undefined: no LFSR is instantiated; plain truncation applies. All test values below assume it is undefined.

Test Plan:
- Reset, freq_i=0, phase_i=0, release -> valid_o rises 3 cycles later; sin_o=13, cos_o=8191 (default params); phase_o=0 constant.
- freq_i=2^30, phase_i=0 -> sin_o repeats 13, 8191, -13, -8191; cos_o repeats 8191, -13, -8191, 13; phase_o steps by 2^30.
- freq_i=0, phase_i stepped 0 -> 2^31 -> sin_o goes 13 -> -13 exactly 2 cycles after the change (stage-1 latency excluded from acc path); phase_o unchanged.
- freq_i=2^30 running, sync_i pulsed one cycle -> acc=0 next edge; 3 edges later sin_o=13, phase_o=0; sequence resumes; valid_o stays 1.
- freq_i=1, long run over 2^PHASEBITS/2^LUTBITS boundaries -> sin_o changes only when acc[31:21] changes; |sin_o| never exceeds 8191; sin_o^2+cos_o^2 stays within 1% of 8191^2.
- rst_i asserted mid-run for 1 cycle with freq_i=2^30 -> next edge all outputs 0, valid_o=0; after release the sequence restarts from 13/8191 with 3-cycle latency.

Source files
------------

// File: rtl/red_pitaya_iq_sincos_gen.sv
// Phase-accumulator NCO with quarter-wave sin/cos table, 3-cycle latency.
// Define IQ_SINCOS_DITHER_EN to add LFSR phase dither below the table address.
module red_pitaya_iq_sincos_gen #(
  parameter int PHASEBITS = 32,
  parameter int LUTBITS   = 11,
  parameter int SINBITS   = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PHASEBITS-1:0]        freq_i,
  input  logic [PHASEBITS-1:0]        phase_i,
  input  logic                        sync_i,
  output logic signed [SINBITS-1:0]   sin_o,
  output logic signed [SINBITS-1:0]   cos_o,
  output logic [PHASEBITS-1:0]        phase_o,
  output logic                        valid_o
);

  localparam int AW  = LUTBITS - 2;
  localparam int N   = 1 << AW;
  localparam int MW  = SINBITS - 1;
  localparam int LOW = PHASEBITS - LUTBITS;

  function automatic logic [MW-1:0] tval(input int k);
    real amp;
    real x;
    amp = real'((1 << MW) - 1);
    x = amp * $sin(2.0 * 3.14159265358979323846
        * (real'(k) + 0.5) / real'(1 << LUTBITS));
    return MW'($rtoi(x + 0.5));
  endfunction

  logic [MW-1:0] lut [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic [MW-1:0] TV = tval(k);
    assign lut[k] = TV;
  end

  logic [PHASEBITS-1:0] dith;

`ifdef IQ_SINCOS_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR MSB lands half an address LSB below the table index
  if (LOW >= 16) begin : g_pad
    assign dith = PHASEBITS'(lfsr_q) << (LOW - 16);
  end else begin : g_trunc
    assign dith = PHASEBITS'(lfsr_q >> (16 - LOW));
  end
`else
  assign dith = '0;
`endif

  logic [PHASEBITS-1:0] acc_q, acc_d;
  logic [PHASEBITS-1:0] ph1_q, ph2_q, ph3_q;
  logic [LUTBITS-1:0]   p_q;
  logic [MW-1:0]        s_mag_q, c_mag_q;
  logic                 s_sgn_q, c_sgn_q;
  logic [SINBITS-1:0]   sin_q, cos_q;
  logic [1:0]           cnt_q;

  logic [LUTBITS-1:0]   pc;
  logic [AW-1:0]        s_addr, c_addr;

  always_comb begin
    acc_d  = sync_i ? '0 : acc_q + freq_i;
    pc     = p_q + LUTBITS'(N);
    s_addr = p_q[LUTBITS-2] ? ~p_q[AW-1:0] : p_q[AW-1:0];
    c_addr = pc[LUTBITS-2] ? ~pc[AW-1:0] : pc[AW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      p_q     <= '0;
      ph1_q   <= '0;
      ph2_q   <= '0;
      ph3_q   <= '0;
      s_mag_q <= '0;
      c_mag_q <= '0;
      s_sgn_q <= 1'b0;
      c_sgn_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      p_q     <= LUTBITS'((acc_q + phase_i + dith) >> LOW);
      ph1_q   <= acc_q;
      ph2_q   <= ph1_q;
      ph3_q   <= ph2_q;
      s_mag_q <= lut[s_addr];
      c_mag_q <= lut[c_addr];
      s_sgn_q <= p_q[LUTBITS-1];
      c_sgn_q <= pc[LUTBITS-1];
      sin_q   <= s_sgn_q ? -{1'b0, s_mag_q} : {1'b0, s_mag_q};
      cos_q   <= c_sgn_q ? -{1'b0, c_mag_q} : {1'b0, c_mag_q};
      if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
    end
  end

  assign sin_o   = sin_q;
  assign cos_o   = cos_q;
  assign phase_o = ph3_q;
  assign valid_o = (cnt_q == 2'd3);

endmodule

// File: tb/tb_red_pitaya_iq_sincos_gen.sv
// Bench for red_pitaya_iq_sincos_gen: directed vector table plus
// randomized run against a trigonometric reference model.
module tb_red_pitaya_iq_sincos_gen;

  localparam logic [31:0] Q1 = 32'h4000_0000;
  localparam logic [31:0] H  = 32'h8000_0000;
  localparam logic [31:0] Q3 = 32'hC000_0000;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic sync_i = 1'b0;
  logic [31:0] freq_i = '0;
  logic [31:0] phase_i = '0;
  logic signed [13:0] sin_o, cos_o;
  logic [31:0] phase_o;
  logic valid_o;

  always #5 clk = ~clk;

  red_pitaya_iq_sincos_gen dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .freq_i  (freq_i),
    .phase_i (phase_i),
    .sync_i  (sync_i),
    .sin_o   (sin_o),
    .cos_o   (cos_o),
    .phase_o (phase_o),
    .valid_o (valid_o)
  );

  typedef struct {
    bit          r;
    bit          s;
    logic [31:0] f;
    logic [31:0] p;
    bit          c;
    int          es;
    int          ec;
    logic [31:0] ep;
    bit          ev;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic [31:0] ph;
  } stg_t;

  vec_t tbl[$];
  stg_t pipe[$];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] acc_m;
  bit m_zero, m_valid;
  int m_sin, m_cos;
  logic [31:0] m_ph;

  function automatic int ref_val(logic [31:0] p, bit cosine);
    real a, v;
    int j;
    j = int'(p >> 21);
    a = 2.0 * PI * (real'(j) + 0.5) / 2048.0;
    v = 8191.0 * (cosine ? $cos(a) : $sin(a));
    return (v < 0.0) ? -$rtoi(-v + 0.5) : $rtoi(v + 0.5);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(bit r, bit s, logic [31:0] f, logic [31:0] p,
                     bit c, int es, int ec, logic [31:0] ep, bit ev);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.p = p; v.c = c;
    v.es = es; v.ec = ec; v.ep = ep; v.ev = ev;
    tbl.push_back(v);
  endtask

  task automatic model_edge(bit r, bit s, logic [31:0] f, logic [31:0] p);
    stg_t e;
    if (r) begin
      acc_m = '0;
      pipe.delete();
      m_zero = 1'b1;
      m_valid = 1'b0;
    end else begin
      m_zero = 1'b0;
      e.p = acc_m + p;
      e.ph = acc_m;
      pipe.push_back(e);
      acc_m = s ? 32'd0 : acc_m + f;
      if (pipe.size() == 3) begin
        e = pipe.pop_front();
        m_valid = 1'b1;
        m_sin = ref_val(e.p, 1'b0);
        m_cos = ref_val(e.p, 1'b1);
        m_ph = e.ph;
      end
    end
  endtask

  task automatic step(bit r, bit s, logic [31:0] f, logic [31:0] p);
    rst_i = r;
    sync_i = s;
    freq_i = f;
    phase_i = p;
    @(posedge clk);
    #1;
    model_edge(r, s, f, p);
  endtask

  task automatic model_check();
    longint pw;
    if (m_zero) begin
      chk("rst_sin", sin_o, 0);
      chk("rst_cos", cos_o, 0);
      chk("rst_phase", phase_o, 0);
      chk("rst_valid", valid_o, 0);
    end else begin
      chk("valid", valid_o, m_valid);
      if (m_valid) begin
        chk("sin", sin_o, m_sin);
        chk("cos", cos_o, m_cos);
        chk("phase", phase_o, m_ph);
        chk("sin_range", (sin_o <= 8191 && sin_o >= -8191), 1);
        pw = longint'(sin_o) * sin_o + longint'(cos_o) * cos_o;
        chk("power", (pw > 67092481 - 670925 && pw < 67092481 + 670925), 1);
      end
    end
  endtask

  initial begin
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 13, 8191, 0, 1);
    add(0, 0, 0, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 8191, -13, Q1, 1);
    add(0, 0, Q1, 0, 1, -13, -8191, H, 1);
    add(0, 0, Q1, 0, 1, -8191, 13, Q3, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 8191, -13, Q1, 1);
    add(0, 1, Q1, 0, 1, -13, -8191, H, 1);
    add(0, 0, Q1, 0, 1, -8191, 13, Q3, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 8191, -13, Q1, 1);
    add(1, 0, Q1, 0, 1, 0, 0, 0, 0);
    add(0, 0, Q1, 0, 0, 0, 0, 0, 0);
    add(0, 0, Q1, 0, 0, 0, 0, 0, 0);
    add(0, 0, Q1, 0, 1, 13, 8191, 0, 1);
    add(0, 0, Q1, 0, 1, 8191, -13, Q1, 1);
    add(0, 0, Q1, 0, 1, -13, -8191, H, 1);
    add(0, 1, 0, 0, 1, -8191, 13, Q3, 1);
    add(0, 0, 0, 0, 1, 13, 8191, 0, 1);
    add(0, 0, 0, 0, 1, 8191, -13, Q1, 1);
    add(0, 0, 0, 0, 1, 13, 8191, 0, 1);
    add(0, 0, 0, H, 1, 13, 8191, 0, 1);
    add(0, 0, 0, H, 1, 13, 8191, 0, 1);
    add(0, 0, 0, H, 1, -13, -8191, 0, 1);
    add(0, 0, 0, H, 1, -13, -8191, 0, 1);
    add(1, 1, Q1, H, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].p);
      chk($sformatf("vec%0d_valid", i), valid_o, tbl[i].ev);
      if (tbl[i].c) begin
        chk($sformatf("vec%0d_sin", i), sin_o, tbl[i].es);
        chk($sformatf("vec%0d_cos", i), cos_o, tbl[i].ec);
        chk($sformatf("vec%0d_phase", i), phase_o, tbl[i].ep);
      end
    end

    // slow sweep across a table-address boundary
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      model_check();
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 32'd1, 32'h0020_0000 - 32'd5);
      model_check();
    end

    // Nyquist rate: sine alternates sign every sample
    for (int i = 0; i < 10; i++) begin
      step(0, 0, H, 0);
      model_check();
    end

    // reset and sync together mid-run
    step(1, 1, Q1, 0);
    model_check();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f, p;
      bit r, s;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 31) == 0);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 << 22)
                                       : $urandom;
      p = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(r, s, f, p);
      model_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
